// File: rtl/shift_ctrl_pkg.sv
// Shared definitions for the shift-register sequencer.
//   state_t : controller state encoding (IDLE/SHIFT/LATCH)
//   cnt_w() : width of a 0..n-1 counter, never narrower than one bit
package shift_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_LATCH = 2'd2
  } state_t;

  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/shift_ctrl_if.sv
// Handshake and shift-register control bundle for shift_ctrl.
//   in_data/in_valid/in_ready : parallel word handshake (producer -> controller)
//   abort                     : synchronous frame cancel
//   sr_din/sr_shift/sr_clr    : serial data, shift enable, clear to the register
//   sr_latch/done/busy        : word-complete strobes and frame-in-progress flag
interface shift_ctrl_if #(parameter int WIDTH = 4);
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic             abort;
  logic             sr_din;
  logic             sr_shift;
  logic             sr_clr;
  logic             sr_latch;
  logic             busy;
  logic             done;

  modport master (
    output in_data, in_valid, abort,
    input  in_ready, sr_din, sr_shift, sr_clr, sr_latch, busy, done
  );

  modport slave (
    input  in_data, in_valid, abort,
    output in_ready, sr_din, sr_shift, sr_clr, sr_latch, busy, done
  );
endinterface

// File: rtl/shift_tick_gen.sv
// Bit-period tick generator. Counts DIV cycles per period and raises a
// registered tick on the last cycle of each period.
//   clk, rst : clock, async active-low reset
//   clr      : start a fresh period; its first cycle is the next one
//   en       : keep the running period going into the next cycle
//   tick     : high during the last cycle of a period
// With neither clr nor en the generator parks at zero with tick low.
module shift_tick_gen
  import shift_ctrl_pkg::*;
#(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int             CW   = cnt_w(DIV);
  localparam logic [CW-1:0]  LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;

  // cnt tracks the position of the current cycle inside its period, so
  // tick is decided one edge early and can be a flop.
  always_comb begin
    cnt_nxt = (cnt == LAST) ? '0 : cnt + CW'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (clr) begin
      cnt  <= '0;
      tick <= (LAST == '0);
    end else if (en) begin
      cnt  <= cnt_nxt;
      tick <= (cnt_nxt == LAST);
    end else begin
      cnt  <= '0;
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/shift_ctrl.sv
// Serialiser that feeds a serial-in shift register from a parallel word.
// A word taken on the valid/ready handshake is shifted out MSB-first, one
// sr_shift pulse per DIV-cycle bit period, followed by a one-cycle
// sr_latch/done strobe. abort during a frame returns to IDLE and pulses sr_clr.
//   clk, rst : clock, async active-low reset
//   bus      : shift_ctrl_if slave (handshake in, register controls out)
module shift_ctrl
  import shift_ctrl_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DIV   = 1
) (
  input  logic         clk,
  input  logic         rst,
  shift_ctrl_if.slave  bus
);

  localparam int BW = $clog2(WIDTH);

  state_t           state;
  logic [WIDTH-1:0] hold;
  logic [BW-1:0]    bit_cnt;
  logic             tick;
  logic             accept;
  logic             last_bit;
  logic             run;

  // abort wins over a simultaneous in_valid in IDLE
  assign accept   = (state == ST_IDLE) && bus.in_valid && !bus.abort;
  assign last_bit = (bit_cnt == '0);
  // The period keeps running only while SHIFT continues past this edge.
  assign run      = (state == ST_SHIFT) && !bus.abort && !(tick && last_bit);

  shift_tick_gen #(.DIV(DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .en   (run),
    .clr  (accept),
    .tick (tick)
  );

  assign bus.sr_shift = tick;
  assign bus.in_ready = (state == ST_IDLE);
  assign bus.busy     = (state != ST_IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= ST_IDLE;
      hold         <= '0;
      bit_cnt      <= '0;
      bus.sr_din   <= 1'b0;
      bus.sr_clr   <= 1'b0;
      bus.sr_latch <= 1'b0;
      bus.done     <= 1'b0;
    end else begin
      bus.sr_clr   <= 1'b0;
      bus.sr_latch <= 1'b0;
      bus.done     <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            hold       <= bus.in_data;
            bit_cnt    <= BW'(WIDTH - 1);
            bus.sr_din <= bus.in_data[WIDTH-1];
            state      <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (bus.abort) begin
            state      <= ST_IDLE;
            bus.sr_clr <= 1'b1;
            bus.sr_din <= 1'b0;
          end else if (tick) begin
            if (last_bit) begin
              state        <= ST_LATCH;
              bus.sr_latch <= 1'b1;
              bus.done     <= 1'b1;
              bus.sr_din   <= 1'b0;
            end else begin
              // present the next bit for the whole coming period
              bit_cnt    <= bit_cnt - BW'(1);
              bus.sr_din <= hold[bit_cnt - BW'(1)];
            end
          end
        end
        ST_LATCH: begin
          state <= ST_IDLE;
          if (bus.abort) bus.sr_clr <= 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_ctrl.sv
module tb_shift_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  shift_ctrl_if #(.WIDTH(4)) b0 ();
  shift_ctrl_if #(.WIDTH(4)) b1 ();

  shift_ctrl #(.WIDTH(4), .DIV(1)) u0 (.clk(clk), .rst(rst), .bus(b0.slave));
  shift_ctrl #(.WIDTH(4), .DIV(3)) u1 (.clk(clk), .rst(rst), .bus(b1.slave));

  int nvec = 0;
  int nmis = 0;

  // frame-schedule model: per DUT, whether a frame is live and which cycle of it we are in
  bit         act   [2];
  int         k     [2];
  logic [3:0] w     [2];
  bit         clrp  [2];
  logic [3:0] q     [2];   // shift-register datapath model
  int         acc_cyc [2];
  int         cyc = 0;
  logic [3:0] latq0 [$];
  logic [3:0] latq1 [$];
  int         latoff0 [$];
  int         latoff1 [$];
  int         shq1 [$];

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    nvec++;
    if (a !== e) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask

  task automatic model_step(input int id, input int D, input logic [3:0] wd,
                            input logic vld, input logic abt,
                            input logic o_rdy, input logic o_din, input logic o_shift,
                            input logic o_clr, input logic o_latch, input logic o_busy,
                            input logic o_done);
    int  wdl;
    int  bi;
    bit  sh, lt;
    string p;
    wdl = 4 * D;
    p = $sformatf("d%0d@%0d", id, cyc);
    if (!rst) begin
      act[id] = 0; clrp[id] = 0; q[id] = 4'd0;
      chk({p, " rst.in_ready"}, o_rdy, 1);
      chk({p, " rst.busy"},     o_busy, 0);
      chk({p, " rst.sr_din"},   o_din, 0);
      chk({p, " rst.sr_shift"}, o_shift, 0);
      chk({p, " rst.sr_clr"},   o_clr, 0);
      chk({p, " rst.sr_latch"}, o_latch, 0);
      chk({p, " rst.done"},     o_done, 0);
      return;
    end
    sh = act[id] && k[id] >= 1 && k[id] <= wdl;
    lt = act[id] && k[id] == wdl + 1;
    chk({p, " in_ready"}, o_rdy,   !(sh || lt));
    chk({p, " busy"},     o_busy,  sh || lt);
    chk({p, " sr_shift"}, o_shift, sh && (k[id] % D == 0));
    chk({p, " sr_latch"}, o_latch, lt);
    chk({p, " done"},     o_done,  lt);
    chk({p, " sr_clr"},   o_clr,   clrp[id]);
    if (sh) begin
      bi = 3 - (k[id] - 1) / D;
      chk({p, " sr_din"}, o_din, w[id][bi]);
    end
    // datapath: register contents at the latch must equal the word
    if (o_latch) begin
      chk({p, " q@latch"}, q[id], w[id]);
      if (id == 0) begin latq0.push_back(q[id]); latoff0.push_back(cyc - acc_cyc[id]); end
      else         begin latq1.push_back(q[id]); latoff1.push_back(cyc - acc_cyc[id]); end
    end
    if (id == 1 && o_shift) shq1.push_back(cyc - acc_cyc[1]);
    if (o_clr)        q[id] = 4'd0;
    else if (o_shift) q[id] = {q[id][2:0], o_din};
    // advance the schedule with this cycle's inputs
    clrp[id] = 0;
    if (act[id] && abt) begin
      act[id] = 0; clrp[id] = 1;
    end else if (act[id]) begin
      if (k[id] == wdl + 1) act[id] = 0;
      else k[id]++;
    end else if (vld && !abt) begin
      act[id] = 1; k[id] = 1; w[id] = wd; acc_cyc[id] = cyc;
    end
  endtask

  always @(negedge clk) begin
    model_step(0, 1, b0.in_data, b0.in_valid, b0.abort, b0.in_ready, b0.sr_din,
               b0.sr_shift, b0.sr_clr, b0.sr_latch, b0.busy, b0.done);
    model_step(1, 3, b1.in_data, b1.in_valid, b1.abort, b1.in_ready, b1.sr_din,
               b1.sr_shift, b1.sr_clr, b1.sr_latch, b1.busy, b1.done);
    cyc++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] exp0 [4];
    logic [3:0] exp1 [2];
    int         exsh [4];
    b0.in_data = '0; b0.in_valid = 0; b0.abort = 0;
    b1.in_data = '0; b1.in_valid = 0; b1.abort = 0;
    #1 rst = 1'b0;
    repeat (2) step();
    rst = 1'b1;
    step();

    // word 1011, DIV=1: latch 5 cycles after acceptance, ready at 6
    b0.in_data = 4'b1011; b0.in_valid = 1;
    step();
    b0.in_valid = 0; b0.in_data = '0;
    repeat (4) step();
    chk("t1 sr_latch@5", b0.sr_latch, 1);
    chk("t1 done@5",     b0.done, 1);
    step();
    chk("t1 in_ready@6", b0.in_ready, 1);
    repeat (2) step();

    // word 0110, DIV=3
    b1.in_data = 4'b0110; b1.in_valid = 1;
    step();
    b1.in_valid = 0; b1.in_data = '0;
    repeat (16) step();

    // back-to-back: 1111 held valid during a 0001 frame
    b0.in_data = 4'b0001; b0.in_valid = 1;
    step();
    b0.in_data = 4'b1111;
    repeat (5) step();
    chk("t3 in_ready@6", b0.in_ready, 1);
    step();
    b0.in_valid = 0;
    chk("t3 busy after 2nd accept", b0.busy, 1);
    repeat (8) step();

    // abort at cycle 2 of a 1010 frame
    b0.in_data = 4'b1010; b0.in_valid = 1;
    step();
    b0.in_valid = 0;
    step();
    b0.abort = 1;
    step();
    b0.abort = 0;
    chk("t4 sr_clr@3",   b0.sr_clr, 1);
    chk("t4 in_ready@3", b0.in_ready, 1);
    chk("t4 sr_latch@3", b0.sr_latch, 0);
    repeat (3) step();
    chk("t4 q cleared", q[0], 0);

    // async reset mid-SHIFT on both, then 1100 on both
    b0.in_data = 4'b0111; b0.in_valid = 1;
    b1.in_data = 4'b1001; b1.in_valid = 1;
    step();
    b0.in_valid = 0; b1.in_valid = 0;
    repeat (2) step();
    #2 rst = 1'b0;
    #1;
    chk("t5 d0 in_ready async", b0.in_ready, 1);
    chk("t5 d0 busy async",     b0.busy, 0);
    chk("t5 d0 sr_shift async", b0.sr_shift, 0);
    chk("t5 d0 sr_din async",   b0.sr_din, 0);
    chk("t5 d1 busy async",     b1.busy, 0);
    chk("t5 d1 in_ready async", b1.in_ready, 1);
    step();
    rst = 1'b1;
    step();
    b0.in_data = 4'b1100; b0.in_valid = 1;
    b1.in_data = 4'b1100; b1.in_valid = 1;
    step();
    b0.in_valid = 0; b1.in_valid = 0;
    repeat (16) step();

    // abort with in_valid in IDLE: nothing accepted
    b0.in_data = 4'b1111; b0.in_valid = 1; b0.abort = 1;
    b1.in_data = 4'b1111; b1.in_valid = 1; b1.abort = 1;
    step();
    b0.in_valid = 0; b0.abort = 0;
    b1.in_valid = 0; b1.abort = 0;
    chk("t6 d0 busy",     b0.busy, 0);
    chk("t6 d1 busy",     b1.busy, 0);
    chk("t6 d0 in_ready", b0.in_ready, 1);
    chk("t6 d0 sr_clr",   b0.sr_clr, 0);
    repeat (3) step();

    // pin the model with hand-computed results
    exp0 = '{4'b1011, 4'b0001, 4'b1111, 4'b1100};
    exp1 = '{4'b0110, 4'b1100};
    exsh = '{3, 6, 9, 12};
    chk("d0 latch count", latq0.size(), 4);
    if (latq0.size() == 4)
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("d0 latched word %0d", i), latq0[i], exp0[i]);
        chk($sformatf("d0 latch offset %0d", i), latoff0[i], 5);
      end
    chk("d1 latch count", latq1.size(), 2);
    if (latq1.size() == 2)
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("d1 latched word %0d", i), latq1[i], exp1[i]);
        chk($sformatf("d1 latch offset %0d", i), latoff1[i], 13);
      end
    chk("d1 shift log >= 4", shq1.size() >= 4, 1);
    if (shq1.size() >= 4)
      for (int i = 0; i < 4; i++)
        chk($sformatf("d1 shift offset %0d", i), shq1[i], exsh[i]);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule

// File: doc/shift_ctrl.md
Name: shift_ctrl

Overview:
- Sequencer that drives a serial-in shift register (clk/rst/din/q style) from a parallel word.
- Accepts a WIDTH-bit word on a valid/ready handshake.
- Serialises the word MSB-first onto the register's data input, with one-cycle shift-enable pulses at a programmable bit rate.
- Pulses a latch strobe once the full word has been shifted in. Sits between the producer logic and the shift-register datapath.

Parameters:
- WIDTH, 4: word length, equal to shift-register depth (≥2).
- DIV, 1: clock cycles per bit period (≥1). Shift pulse on last cycle of each period.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- in_data  in  WIDTH  parallel word to serialise.
- in_valid  in  1  in_data valid.
- in_ready  out  1  controller can accept a word.
- abort  in  1  synchronous cancel of the current frame.
- sr_din  out  1  serial bit to the shift register.
- sr_shift  out  1  one-cycle shift enable for the shift register.
- sr_clr  out  1  one-cycle synchronous clear for the shift register (on abort).
- sr_latch  out  1  one-cycle strobe: register now holds the full word.
- busy  out  1  frame in progress.
- done  out  1  one-cycle frame-complete pulse, coincident with sr_latch.

Behaviour:
- Reset (rst=0, async):
  - state=IDLE; hold reg, bit counter and divider counter cleared.
  - sr_din=0, sr_shift=0, sr_clr=0, sr_latch=0, busy=0, done=0.
  - in_ready=1 (decoded from IDLE).
  - Reset mid-frame abandons the frame immediately; no latch or done pulse is emitted.
- States: IDLE, SHIFT, LATCH. Outputs are registered except in_ready and busy, which are decoded from state.
- IDLE:
  - in_ready=1.
  - Accept when in_valid && in_ready: capture in_data into hold reg; bit_cnt=WIDTH-1; div_cnt=0; go to SHIFT.
- SHIFT:
  - busy=1, in_ready=0.
  - sr_din=hold[bit_cnt], held stable for the whole bit period.
  - div_cnt counts 0..DIV-1. At div_cnt==DIV-1: sr_shift=1 for one cycle and div_cnt wraps to 0.
  - If bit_cnt==0 at that point, go to LATCH; otherwise bit_cnt decrements.
  - With DIV=1, sr_shift is high on every SHIFT cycle.
- LATCH:
  - One cycle. sr_latch=1, done=1, busy=1, in_ready=0.
  - Then go to IDLE unconditionally.
- Latency and throughput:
  - Accept at edge N: shift pulses at cycles N+1 .. N+WIDTH*DIV; latch at N+WIDTH*DIV+1; in_ready high again at N+WIDTH*DIV+2.
  - Throughput: one word per WIDTH*DIV+2 cycles.
- Handshake:
  - in_valid while in_ready=0 is ignored; the producer must hold the word until accepted.
  - in_data is not sampled after acceptance.
- abort:
  - Sampled in SHIFT or LATCH. Forces IDLE next cycle and pulses sr_clr for one cycle.
  - No sr_shift, sr_latch or done is issued in the abort cycle.
  - abort in IDLE is a no-op, and it takes priority over acceptance, so a simultaneous in_valid is not accepted.
- Widths: bit_cnt is $clog2(WIDTH) bits; div_cnt is max(1,$clog2(DIV)) bits. No overflow is possible; both counters wrap explicitly.

Decomposition:
- Shared header/package (shift_ctrl_defs): state encodings ST_IDLE=2'd0, ST_SHIFT=2'd1, ST_LATCH=2'd2, plus the counter-width helper constant.
- One sub-module: shift_tick_gen. Parameter DIV; inputs clk, rst, en, clr; output tick, which goes high on the last cycle of each bit period. Reused for other serial blocks.

Test Plan:
- WIDTH=4, DIV=1, send 4'b1011 accepted at cycle 0 -> sr_din 1,0,1,1 with sr_shift high cycles 1-4; sr_latch=done=1 at cycle 5; in_ready=1 at cycle 6. Shift-register model q=4'b1011 at latch.
- DIV=3, send 4'b0110 -> sr_shift at cycles 3,6,9,12 only; sr_din constant within each 3-cycle period; latch at cycle 13; q=4'b0110.
- in_valid held high with 4'b1111 during a 4'b0001 frame -> second word accepted only at the first in_ready cycle after the latch; q=4'b0001 at the first latch and 4'b1111 at the second.
- abort asserted at cycle 2 of a 4'b1010 frame (DIV=1) -> sr_clr pulse at cycle 3; no sr_latch or done; in_ready=1 at cycle 3; model q=0.
- rst driven low asynchronously mid-SHIFT (between edges) -> all outputs 0 and in_ready=1 immediately. After release, a new word 4'b1100 serialises correctly.
- abort and in_valid together in IDLE -> word not accepted; busy stays 0.
